// File: rtl/dmem_bridge_pkg.sv
// Shared types and sizing helpers for the data-memory bridge.
// XLEN normally comes from the core's global defines; fall back to RV32.
`ifndef XLEN
`define XLEN 32
`endif

package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_e;

    // Timeout counter width for a given limit: $clog2(limit + 1).
    function automatic int unsigned timeout_cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Per-state watchdog: counts enabled cycles and pulses expire_o on the cycle the count
// would reach Limit. A clear in the same cycle takes priority over expiry.
module dmem_timeout_cnt
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW = timeout_cnt_width(Limit);
    localparam logic [CntW-1:0] LastVal = CntW'(Limit - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire_o = enable_i && !clear_i && (cnt_q == LastVal);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expire_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns single-cycle load/store requests from the memory stage into
// req/gnt/rvalid bus transactions, halting the pipeline while one is outstanding.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic [`XLEN-1:0]  mem_addr_i,
    input  logic              mem_read_en_i,
    input  logic              mem_write_en_i,
    input  logic [`XLEN-1:0]  mem_write_data_i,
    output logic [`XLEN-1:0]  mem_read_data_o,
    output logic              halt_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [`XLEN-1:0]  bus_addr_o,
    output logic [`XLEN-1:0]  bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [`XLEN-1:0]  bus_rdata_i
);

    state_e             state_q;
    logic               we_q;
    logic [`XLEN-1:0]   addr_q;
    logic [`XLEN-1:0]   wdata_q;
    logic [`XLEN-1:0]   rdata_q;
    logic               halt_q;
    logic               err_q;
    logic               req_q;

    logic               cnt_clear;
    logic               cnt_en;
    logic               expire;

    // Clear on every state change so each state gets its own full timeout window.
    assign cnt_en    = (state_q != IDLE);
    assign cnt_clear = (state_q == IDLE)
                    || (state_q == REQ    && bus_gnt_i)
                    || (state_q == WAIT_R && bus_rvalid_i);

    dmem_timeout_cnt #(
        .Limit(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i   (clk_i),
        .resetn_i(resetn_i),
        .clear_i (cnt_clear),
        .enable_i(cnt_en),
        .expire_o(expire)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // A simultaneous read and write is treated as a write.
                    if (mem_write_en_i || mem_read_en_i) begin
                        we_q    <= mem_write_en_i;
                        addr_q  <= mem_addr_i;
                        wdata_q <= mem_write_data_i;
                        req_q   <= 1'b1;
                        halt_q  <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            halt_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= WAIT_R;
                        end
                    end else if (expire) begin
                        req_q   <= 1'b0;
                        halt_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        if (!we_q) begin
                            rdata_q <= '0;
                        end
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid_i) begin
                        rdata_q <= bus_rdata_i;
                        halt_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (expire) begin
                        rdata_q <= '0;
                        halt_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    halt_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_read_data_o = rdata_q;
    assign halt_o          = halt_q;
    assign err_o           = err_q;
    assign bus_req_o       = req_q;
    assign bus_we_o        = we_q;
    assign bus_addr_o      = addr_q;
    assign bus_wdata_o     = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed cases plus randomized transactions with
// random bus wait states, checked against a cycle-count model of each transaction.
`ifndef XLEN
`define XLEN 32
`endif

module tb_dmem_bridge;

    localparam int T  = 4;
    localparam int XW = `XLEN;

    logic          clk_i = 1'b0;
    logic          resetn_i;
    logic [XW-1:0] mem_addr_i;
    logic          mem_read_en_i;
    logic          mem_write_en_i;
    logic [XW-1:0] mem_write_data_i;
    logic [XW-1:0] mem_read_data_o;
    logic          halt_o;
    logic          err_o;
    logic          bus_req_o;
    logic          bus_we_o;
    logic [XW-1:0] bus_addr_o;
    logic [XW-1:0] bus_wdata_o;
    logic          bus_gnt_i;
    logic          bus_rvalid_i;
    logic [XW-1:0] bus_rdata_i;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [XW-1:0] exp_rdata;

    dmem_bridge #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i           (clk_i),
        .resetn_i        (resetn_i),
        .mem_addr_i      (mem_addr_i),
        .mem_read_en_i   (mem_read_en_i),
        .mem_write_en_i  (mem_write_en_i),
        .mem_write_data_i(mem_write_data_i),
        .mem_read_data_o (mem_read_data_o),
        .halt_o          (halt_o),
        .err_o           (err_o),
        .bus_req_o       (bus_req_o),
        .bus_we_o        (bus_we_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_gnt_i       (bus_gnt_i),
        .bus_rvalid_i    (bus_rvalid_i),
        .bus_rdata_i     (bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Idle cycles with optional bus noise; nothing may change.
    task automatic idle_gap(input int n, input bit force_rvalid);
        mem_read_en_i  = 1'b0;
        mem_write_en_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus_gnt_i    = 1'($urandom_range(0, 1));
            bus_rvalid_i = force_rvalid ? 1'b1 : 1'($urandom_range(0, 1));
            bus_rdata_i  = XW'($urandom());
            tick();
            chk1("idle_halt", halt_o, 1'b0);
            chk1("idle_err", err_o, 1'b0);
            chk1("idle_req", bus_req_o, 1'b0);
            chk("idle_rdata", mem_read_data_o, exp_rdata);
        end
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
    endtask

    // One transaction issued in the current (IDLE) cycle N. g = grant wait states,
    // r = rvalid wait states. Returns in the first IDLE cycle after completion.
    task automatic run_txn(input bit wr, input bit both, input logic [XW-1:0] addr,
                           input logic [XW-1:0] wdata, input logic [XW-1:0] rdat,
                           input int g, input int r);
        int            req_c;
        int            h;
        bit            tmo;
        logic [XW-1:0] nxt_rdata;
        // Model: cycles in REQ, total halt length, and outcome.
        if (g >= T) begin
            tmo = 1'b1; req_c = T; h = T;
        end else begin
            req_c = g + 1;
            if (wr) begin
                tmo = 1'b0; h = g + 1;
            end else if (r >= T) begin
                tmo = 1'b1; h = g + 1 + T;
            end else begin
                tmo = 1'b0; h = g + 2 + r;
            end
        end
        nxt_rdata = wr ? exp_rdata : (tmo ? '0 : rdat);

        chk1("start_halt", halt_o, 1'b0);
        mem_addr_i       = addr;
        mem_write_data_i = wdata;
        mem_write_en_i   = wr;
        mem_read_en_i    = !wr || both;
        bus_gnt_i        = 1'b0;
        bus_rvalid_i     = 1'b0;
        for (int k = 1; k <= h + 1; k++) begin
            tick();
            if (k <= h) begin
                chk1("busy_halt", halt_o, 1'b1);
                chk1("busy_err", err_o, 1'b0);
                chk1("bus_req", bus_req_o, k <= req_c);
                if (k <= req_c) begin
                    chk1("bus_we", bus_we_o, wr);
                    chk("bus_addr", bus_addr_o, addr);
                    if (wr) chk("bus_wdata", bus_wdata_o, wdata);
                end
                chk("rdata_hold", mem_read_data_o, exp_rdata);
            end else begin
                chk1("done_halt", halt_o, 1'b0);
                chk1("done_err", err_o, tmo);
                chk1("done_req", bus_req_o, 1'b0);
                chk("done_rdata", mem_read_data_o, nxt_rdata);
            end
            // Core inputs are noise while busy.
            mem_write_en_i   = 1'($urandom_range(0, 1));
            mem_read_en_i    = 1'($urandom_range(0, 1));
            mem_addr_i       = XW'($urandom());
            mem_write_data_i = XW'($urandom());
            if (k == h + 1) begin
                mem_write_en_i = 1'b0;
                mem_read_en_i  = 1'b0;
            end
            bus_gnt_i    = (k == g + 1) || (k > req_c && $urandom_range(0, 3) == 0);
            bus_rvalid_i = (!wr && k == g + 2 + r)
                        || ((k <= req_c || k == h + 1) && $urandom_range(0, 3) == 0);
            bus_rdata_i  = (!wr && k == g + 2 + r) ? rdat : XW'($urandom());
        end
        exp_rdata = nxt_rdata;
    endtask

    initial begin
        resetn_i         = 1'b0;
        mem_addr_i       = '0;
        mem_read_en_i    = 1'b0;
        mem_write_en_i   = 1'b0;
        mem_write_data_i = '0;
        bus_gnt_i        = 1'b0;
        bus_rvalid_i     = 1'b0;
        bus_rdata_i      = '0;
        exp_rdata        = '0;

        tick();
        tick();
        chk1("rst_halt", halt_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk1("rst_req", bus_req_o, 1'b0);
        chk1("rst_we", bus_we_o, 1'b0);
        chk("rst_addr", bus_addr_o, '0);
        chk("rst_wdata", bus_wdata_o, '0);
        chk("rst_rdata", mem_read_data_o, '0);
        resetn_i = 1'b1;
        tick();

        // Zero-wait read, 3-grant-wait write, both enables, timeout with late rvalid.
        run_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'hCAFE_0001, 0, 0);
        run_txn(1'b1, 1'b0, 32'h40, 32'h1234_5678, 32'h0, 3, 0);
        run_txn(1'b1, 1'b1, 32'h80, 32'hA5A5_0F0F, 32'hDEAD_BEEF, 0, 0);
        run_txn(1'b0, 1'b0, 32'h104, 32'h0, 32'h1111_2222, 0, T + 3);
        idle_gap(3, 1'b1);

        // Reset while in WAIT_R, then a normal read.
        run_txn(1'b0, 1'b0, 32'h108, 32'h0, 32'h5555_AAAA, 1, 1);
        mem_addr_i    = 32'h200;
        mem_read_en_i = 1'b1;
        tick();
        mem_read_en_i = 1'b0;
        bus_gnt_i     = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        chk1("pre_rst_halt", halt_o, 1'b1);
        #2 resetn_i = 1'b0;
        #1;
        chk1("async_rst_halt", halt_o, 1'b0);
        chk1("async_rst_req", bus_req_o, 1'b0);
        chk1("async_rst_err", err_o, 1'b0);
        chk("async_rst_rdata", mem_read_data_o, '0);
        exp_rdata = '0;
        tick();
        resetn_i = 1'b1;
        idle_gap(2, 1'b1);
        run_txn(1'b0, 1'b0, 32'h300, 32'h0, 32'h0BAD_F00D, 0, 0);

        // Back-to-back read then write, and a write that times out in REQ.
        run_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'h7777_0001, 2, 1);
        run_txn(1'b1, 1'b0, 32'h14, 32'hFEED_0002, 32'h0, 1, 0);
        run_txn(1'b1, 1'b0, 32'h18, 32'h0000_0003, 32'h0, T + 1, 0);
        run_txn(1'b0, 1'b0, 32'h1C, 32'h0, 32'h9999_0004, T - 1, T - 1);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), XW'($urandom()),
                    XW'($urandom()), XW'($urandom()), int'($urandom_range(0, T + 1)),
                    int'($urandom_range(0, T + 1)));
            idle_gap(int'($urandom_range(0, 2)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
